rf_scoreboard: RTL and testbench
================================

Name: rf_scoreboard

Overview:
- Parametrised successor of the core's integer register file for the pipelined miniRV core.
- Configurable data width and register count; x0 hard-wired to zero.
- Adds asynchronous reset clearing, write-to-read bypass and a per-register pending (scoreboard) bit with a pipeline-stall output.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, data width of every register and data port.
- NREG, 32, number of architectural registers, power of two, >= 2; index 0 is the zero register.
- AW, 5, address width; must equal log2(NREG).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- data1  out  XLEN  read data, port 1 (combinational).
- data2  out  XLEN  read data, port 2 (combinational).
- wen  in  1  writeback enable.
- w_addr  in  AW  writeback address.
- w_data  in  XLEN  writeback data.
- iss_en  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  AW  destination of the issuing instruction.
- flush  in  1  squash all in-flight writes; clears every pending bit.
- busy1  out  1  rs1 has an unresolved pending write.
- busy2  out  1  rs2 has an unresolved pending write.
- stall  out  1  busy1 OR busy2.
- pend_cnt  out  AW+1  number of registers currently pending.

Behaviour:
- Reset: on rst high, immediately (no clock needed) set all registers to 0, all pending bits to 0 and pend_cnt to 0. With rst held, data1/data2 = 0, busy1/busy2/stall = 0.
- Zero register:
  - Reads of address 0 always return 0.
  - Writes to 0 are ignored.
  - Issue to 0 never sets a pending bit.
  - busy for address 0 is always 0.
- Write: on a rising clk with wen=1 and w_addr!=0, reg[w_addr] <= w_data.
- Read, combinational:
  - data1 = 0 when rs1=0.
  - Otherwise data1 = w_data when wen=1 and w_addr=rs1 (same-cycle bypass).
  - Otherwise data1 = reg[rs1].
  - data2 follows the same rules using rs2.
- Pending bits, updated on the clk edge:
  - wen=1 with w_addr!=0 clears pend[w_addr].
  - iss_en=1 with iss_rd!=0 sets pend[iss_rd].
  - Same register cleared and set in the same cycle: set wins, because the newer issue owns the register.
  - flush=1 clears all pending bits and takes priority over iss_en. The write itself still occurs if wen=1.
- busy1, combinational: pend[rs1] AND NOT(wen AND w_addr=rs1) AND rs1!=0. The register being written this cycle is resolved through the bypass. busy2 follows the same rule using rs2.
- pend_cnt: registered; always equals the population count of the pending vector after each edge.
  - Net per cycle: +1 set only, -1 clear only, 0 both or neither.
  - Set and clear on different registers: net 0.
  - Set and clear on the same register: net 0, because the bit stays set.
  - flush: pend_cnt goes to 0.
- pend_cnt never exceeds NREG-1 because x0 cannot be pending. No wrap-around is possible.
- Unknown/out-of-range addresses cannot occur (NREG = 2^AW).
- Reset asserted mid-operation: all state clears asynchronously. First writes are accepted on the first clk edge after rst deasserts.
- No internal latency other than one clock for writes and pending updates. Reads and busy are zero-latency.

Test Plan:
- Reset and zero register: rst pulse between edges, then read rs1=5, rs2=0 -> data1=0, data2=0 immediately. Then wen=1, w_addr=0, w_data=0xDEADBEEF, read rs1=0 -> data1=0.
- Write and bypass: wen=1, w_addr=3, w_data=0x12345678, rs1=3 in the same cycle -> data1=0x12345678 before the edge. After the edge with wen=0 -> data1=0x12345678 from storage.
- Scoreboard stall: iss_en=1, iss_rd=7, then rs2=7 -> busy2=1, stall=1, pend_cnt=1. Writeback wen=1, w_addr=7 -> busy2=0 in that cycle (bypass). After the edge, pend_cnt=0.
- Simultaneous set/clear: pend[9]=1, then same cycle wen=1, w_addr=9 and iss_en=1, iss_rd=9 -> after the edge pend[9]=1, pend_cnt unchanged. Separately, wen to reg 4 with issue to reg 6 -> pend_cnt unchanged, pend[4]=0, pend[6]=1.
- Flush: issue regs 1, 2, 3 (pend_cnt=3), then flush=1 with iss_en=1, iss_rd=5 -> after the edge pend_cnt=0, busy=0 for rs1=5 and rs2=2.
- Parametrisation: XLEN=64, NREG=16, AW=4. Write 0xFFFF_0000_FFFF_0001 to reg 15 -> reads back exactly. Issue all of regs 1..15 -> pend_cnt=15. Async rst mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//
// Integer register file for the pipelined miniRV core, with a per-register
// pending (scoreboard) bit. Decode reads operands and marks the destination
// of an issuing instruction as pending. Writeback writes the result and
// clears that pending bit.
//
// Features:
//   - x0 is hard-wired to zero.
//   - Same-cycle write-to-read bypass.
//   - Asynchronous clearing of all state on reset.
//
// Parameters:
//   XLEN  data width of every register and data port
//   NREG  number of architectural registers (power of two, >= 2)
//   AW    address width, equal to log2(NREG)
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   rs1, rs2          read addresses
//   data1, data2      combinational read data (x0 reads as zero, bypassed)
//   wen, w_addr,
//   w_data            writeback port; also clears the pending bit of w_addr
//   iss_en, iss_rd    issue port; sets the pending bit of iss_rd
//   flush             clears every pending bit (the write itself still happens)
//   busy1, busy2      operand has an unresolved pending write
//   stall             busy1 | busy2
//   pend_cnt          registered number of pending registers
// ---------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  input  logic            wen,
  input  logic [AW-1:0]   w_addr,
  input  logic [XLEN-1:0] w_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2,
  output logic            stall,
  output logic [AW:0]     pend_cnt
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     pend_cnt_q, pend_cnt_d;

  // Writes and issues to x0 are dropped here, so x0 never holds data
  // and is never pending.
  logic clr_en, set_en;
  assign clr_en = wen && (w_addr != '0);
  assign set_en = iss_en && (iss_rd != '0) && !flush;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written in this block gets a default first. Without
  // the defaults, paths that skip an assignment would infer latches.
  always_comb begin
    regs_d     = regs_q;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;

    if (clr_en) regs_d[w_addr] = w_data;

    if (flush) begin
      pend_d     = '0;
      pend_cnt_d = '0;
    end else begin
      // Clear first and set second, so the newer issue wins on a collision.
      if (clr_en) pend_d[w_addr] = 1'b0;
      if (set_en) pend_d[iss_rd] = 1'b1;

      // The count tracks real bit transitions. A re-issue to a register
      // that is already pending is not counted, and neither is a write to
      // a register that is not pending.
      if (set_en && !pend_q[iss_rd])
        pend_cnt_d = pend_cnt_d + CNT_ONE;
      if (clr_en && pend_q[w_addr] && !(set_en && (iss_rd == w_addr)))
        pend_cnt_d = pend_cnt_d - CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // NOTE: the storage array is in the asynchronous reset on purpose. The
  // whole file must read as zero straight out of reset, so it is built from
  // resettable flops rather than from a RAM macro. Sequential state uses
  // non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports and scoreboard outputs (zero latency)
  // -------------------------------------------------------------------------
  // While rst is held, the outputs are forced to zero. This also masks the
  // write bypass, which would otherwise show w_data during reset.
  logic hit1, hit2;
  assign hit1 = wen && (w_addr == rs1);
  assign hit2 = wen && (w_addr == rs2);

  always_comb begin
    data1 = '0;
    data2 = '0;
    if (!rst && (rs1 != '0)) data1 = hit1 ? w_data : regs_q[rs1];
    if (!rst && (rs2 != '0)) data2 = hit2 ? w_data : regs_q[rs2];
  end

  // A register being written back this cycle is already resolved through
  // the bypass, so it does not count as busy.
  assign busy1    = !rst && (rs1 != '0) && pend_q[rs1] && !hit1;
  assign busy2    = !rst && (rs2 != '0) && pend_q[rs2] && !hit2;
  assign stall    = busy1 || busy2;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rf_scoreboard
//
// Self-checking bench for rf_scoreboard. Two instances share the clock:
//   - u_dut:   default XLEN=32, NREG=32
//   - u_dut64: XLEN=64, NREG=16
//
// Test sections:
//   1. A directed vector table.
//   2. Hand-written reset and async-reset sequences.
//   3. A randomized run against a behavioural array model.
// ---------------------------------------------------------------------------
module tb_rf_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Default-size instance
  // ---------------------------------------------------------------------------
  logic        rst;
  logic [4:0]  rs1, rs2, w_addr, iss_rd;
  logic [31:0] data1, data2, w_data;
  logic        wen, iss_en, flush, busy1, busy2, stall;
  logic [5:0]  pend_cnt;

  rf_scoreboard u_dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .data1(data1), .data2(data2),
    .wen(wen), .w_addr(w_addr), .w_data(w_data), .iss_en(iss_en),
    .iss_rd(iss_rd), .flush(flush), .busy1(busy1), .busy2(busy2),
    .stall(stall), .pend_cnt(pend_cnt)
  );

  // ---------------------------------------------------------------------------
  // 64-bit, 16-register instance
  // ---------------------------------------------------------------------------
  logic        b_rst;
  logic [3:0]  b_rs1, b_rs2, b_w_addr, b_iss_rd;
  logic [63:0] b_data1, b_data2, b_w_data;
  logic        b_wen, b_iss_en, b_flush, b_busy1, b_busy2, b_stall;
  logic [4:0]  b_pend_cnt;

  rf_scoreboard #(.XLEN(64), .NREG(16), .AW(4)) u_dut64 (
    .clk(clk), .rst(b_rst), .rs1(b_rs1), .rs2(b_rs2), .data1(b_data1),
    .data2(b_data2), .wen(b_wen), .w_addr(b_w_addr), .w_data(b_w_data),
    .iss_en(b_iss_en), .iss_rd(b_iss_rd), .flush(b_flush), .busy1(b_busy1),
    .busy2(b_busy2), .stall(b_stall), .pend_cnt(b_pend_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wen = 1'b0; w_addr = '0; w_data = '0; iss_en = 1'b0; iss_rd = '0;
    flush = 1'b0; rs1 = '0; rs2 = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs for one cycle, the expected combinational
  // outputs in that cycle, and the expected pend_cnt after the edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wen;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic [31:0] e_d1, e_d2;
    logic        e_b1, e_b2;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model for the randomized run.
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  initial begin
    vecs.push_back('{1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 1'b0, 5'd3, 5'd7, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 32'h0, 32'h0,         1'b0, 1'b1, 6'd1});
    vecs.push_back('{1'b1, 5'd7, 32'hAAAA_5555, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 32'h0, 32'hAAAA_5555, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b0, 5'd9, 5'd7, 32'h0, 32'hAAAA_5555, 1'b0, 1'b0, 6'd1});
    vecs.push_back('{1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 32'h99, 32'h0,        1'b0, 1'b0, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b1, 5'd4, 1'b0, 5'd9, 5'd0, 32'h99, 32'h0,        1'b1, 1'b0, 6'd2});
    vecs.push_back('{1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd6, 1'b0, 5'd4, 5'd6, 32'h44, 32'h0,        1'b0, 1'b0, 6'd2});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd4, 5'd6, 32'h44, 32'h0,        1'b0, 1'b1, 6'd2});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b1, 5'd1, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0,         1'b0, 1'b0, 6'd3});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b1, 5'd2, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0,         1'b1, 1'b0, 6'd4});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0,         1'b1, 1'b1, 6'd5});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 1'b1, 5'd5, 5'd2, 32'h0, 32'h0,         1'b0, 1'b1, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd5, 5'd2, 32'h0, 32'h0,         1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd3, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0,         1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd5, 32'h5555_AAAA, 1'b1, 5'd5, 1'b1, 5'd5, 5'd9, 32'h5555_AAAA, 32'h99, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0, 6'd0});

    // Idle the 64-bit instance under reset while the 32-bit one is tested.
    b_rst = 1'b1; b_wen = 1'b0; b_w_addr = '0; b_w_data = '0; b_iss_en = 1'b0;
    b_iss_rd = '0; b_flush = 1'b0; b_rs1 = '0; b_rs2 = '0;

    // --- Reset held: outputs are zero even when a bypass would apply ---
    idle_inputs();
    rst = 1'b1;
    #2;
    wen = 1'b1; w_addr = 5'd5; w_data = 32'hCAFE_F00D; rs1 = 5'd5; rs2 = 5'd0;
    #1;
    check("rst_data1",    data1,    64'h0);
    check("rst_data2",    data2,    64'h0);
    check("rst_stall",    stall,    64'h0);
    check("rst_pend_cnt", pend_cnt, 64'h0);
    idle_inputs();
    rst = 1'b0;
    next_cycle();

    // --- Directed table ---
    foreach (vecs[i]) begin
      wen = vecs[i].wen; w_addr = vecs[i].w_addr; w_data = vecs[i].w_data;
      iss_en = vecs[i].iss_en; iss_rd = vecs[i].iss_rd; flush = vecs[i].flush;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      #1;
      check($sformatf("v%0d_data1", i), data1, vecs[i].e_d1);
      check($sformatf("v%0d_data2", i), data2, vecs[i].e_d2);
      check($sformatf("v%0d_busy1", i), busy1, vecs[i].e_b1);
      check($sformatf("v%0d_busy2", i), busy2, vecs[i].e_b2);
      check($sformatf("v%0d_stall", i), stall, vecs[i].e_b1 | vecs[i].e_b2);
      next_cycle();
      check($sformatf("v%0d_pend_cnt", i), pend_cnt, vecs[i].e_cnt);
    end

    // --- Async reset mid-operation, then first write after release ---
    idle_inputs(); iss_en = 1'b1; iss_rd = 5'd8;
    next_cycle();
    idle_inputs(); wen = 1'b1; w_addr = 5'd10; w_data = 32'h0000_1010;
    next_cycle();
    idle_inputs(); rs1 = 5'd10; rs2 = 5'd8;
    #1;
    check("mid_pre_data1", data1,    64'h1010);
    check("mid_pre_busy2", busy2,    64'h1);
    check("mid_pre_cnt",   pend_cnt, 64'h1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_data1", data1,    64'h0);
    check("mid_rst_busy2", busy2,    64'h0);
    check("mid_rst_stall", stall,    64'h0);
    check("mid_rst_cnt",   pend_cnt, 64'h0);
    rst = 1'b0;
    wen = 1'b1; w_addr = 5'd10; w_data = 32'h0000_2020;
    next_cycle();
    wen = 1'b0;
    #1;
    check("post_rst_write", data1, 64'h2020);
    check("post_rst_busy2", busy2, 64'h0);

    // --- Randomized run against the array model ---
    idle_inputs();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    next_cycle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] e_d1, e_d2;
      logic        e_b1, e_b2;
      wen    = 1'($urandom_range(0, 1));
      w_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      w_data = $urandom;
      iss_en = ($urandom_range(0, 9) < 6);
      iss_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      flush  = ($urandom_range(0, 15) == 0);
      rs1    = 5'($urandom_range(0, 7));
      rs2    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      #1;
      // Expected outputs from the register-file rules.
      e_d1 = (rs1 == 0) ? 32'h0 : ((wen && w_addr == rs1) ? w_data : m_regs[rs1]);
      e_d2 = (rs2 == 0) ? 32'h0 : ((wen && w_addr == rs2) ? w_data : m_regs[rs2]);
      e_b1 = (rs1 != 0) && m_pend[rs1] && !(wen && w_addr == rs1);
      e_b2 = (rs2 != 0) && m_pend[rs2] && !(wen && w_addr == rs2);
      check("rnd_data1", data1, e_d1);
      check("rnd_data2", data2, e_d2);
      check("rnd_busy1", busy1, e_b1);
      check("rnd_busy2", busy2, e_b2);
      check("rnd_stall", stall, e_b1 | e_b2);
      // Update the model as of the edge.
      if (wen && w_addr != 0) m_regs[w_addr] = w_data;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      end else begin
        if (wen && w_addr != 0)    m_pend[w_addr] = 1'b0;
        if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      end
      next_cycle();
      check("rnd_pend_cnt", pend_cnt, 64'(model_count()));
    end
    idle_inputs();

    // --- 64-bit, 16-register instance ---
    b_rst = 1'b0;
    next_cycle();
    b_wen = 1'b1; b_w_addr = 4'd15; b_w_data = 64'hFFFF_0000_FFFF_0001; b_rs1 = 4'd15;
    #1;
    check("w64_bypass", b_data1, 64'hFFFF_0000_FFFF_0001);
    next_cycle();
    b_wen = 1'b0;
    #1;
    check("w64_stored", b_data1, 64'hFFFF_0000_FFFF_0001);
    for (int r = 1; r < 16; r++) begin
      b_iss_en = 1'b1; b_iss_rd = 4'(r);
      next_cycle();
    end
    b_iss_en = 1'b0; b_iss_rd = '0; b_rs2 = 4'd15;
    #1;
    check("w64_cnt_full", b_pend_cnt, 64'd15);
    check("w64_busy1",    b_busy1,    64'h1);
    check("w64_stall",    b_stall,    64'h1);
    b_rst = 1'b1;
    #1;
    check("w64_rst_data1", b_data1,    64'h0);
    check("w64_rst_data2", b_data2,    64'h0);
    check("w64_rst_stall", b_stall,    64'h0);
    check("w64_rst_cnt",   b_pend_cnt, 64'h0);
    b_rst = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
